// File: rtl/caxi4interconnect_hold_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : caxi4interconnect_hold_reg_arb_pkg
// Brief   : State encoding and round-robin search shared by the hold-reg arbiter
// Revision: 1.0
// ============================================================================
package caxi4interconnect_hold_reg_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned C_MAX_SRC = 8;

  // First set bit of valid at or above ptr, wrapping modulo num_src.
  // Scanned from the farthest offset down so the nearest candidate wins.
  function automatic int unsigned rr_search(
    input logic [C_MAX_SRC-1:0] valid,
    input int unsigned          ptr,
    input int unsigned          num_src
  );
    int unsigned idx;
    int unsigned res;
    res = ptr;
    for (int i = C_MAX_SRC - 1; i >= 0; i--) begin
      idx = (ptr + unsigned'(i)) % num_src;
      if ((unsigned'(i) < num_src) && valid[idx[2:0]]) begin
        res = idx;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/caxi4interconnect_hold_reg_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : caxi4interconnect_Hold_Reg_Ctrl
// Brief   : Single-entry holding register handshake (pass_data / get-next / valid)
// Revision: 1.0
// ============================================================================
module caxi4interconnect_Hold_Reg_Ctrl (
  input  logic clk,
  input  logic rst,
  input  logic src_data_valid,
  input  logic get_next_data_hold,
  output logic get_next_data_src,
  output logic hold_data_valid
);

  logic w_pass_data;
  logic r_hold_valid;

  // The register may take a beat when it is empty or being drained this cycle.
  assign w_pass_data       = get_next_data_hold | ~r_hold_valid;
  assign get_next_data_src = src_data_valid & w_pass_data;
  assign hold_data_valid   = r_hold_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
    end else if (w_pass_data) begin
      r_hold_valid <= get_next_data_src;
    end
  end

endmodule
`default_nettype wire

// File: rtl/caxi4interconnect_hold_reg_arb.sv
`default_nettype none
// ============================================================================
// Module  : caxi4interconnect_hold_reg_arb
// Brief   : Round-robin burst-locked arbiter feeding one shared holding register
// Revision: 1.0
// ============================================================================
module caxi4interconnect_hold_reg_arb
  import caxi4interconnect_hold_reg_arb_pkg::*;
#(
  parameter  int NUM_SRC      = 4,
  parameter  int DATA_WIDTH   = 64,
  localparam int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_data_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            get_next_data_src,
  input  logic                          get_next_data_hold,
  output logic                          hold_data_valid,
  output logic [DATA_WIDTH-1:0]         hold_data,
  output logic                          hold_last,
  output logic [SRC_ID_WIDTH-1:0]       hold_src_id,
  output logic                          busy
);

  arb_state_t                r_state;
  logic [SRC_ID_WIDTH-1:0]   r_grant_id;
  logic [SRC_ID_WIDTH-1:0]   r_rr_ptr;
  logic [DATA_WIDTH-1:0]     r_hold_data;
  logic                      r_hold_last;
  logic [SRC_ID_WIDTH-1:0]   r_hold_src_id;

  logic [C_MAX_SRC-1:0]      w_valid_pad;
  int unsigned               w_search;
  logic [SRC_ID_WIDTH-1:0]   w_search_id;
  logic                      w_grant_valid;
  logic                      w_xfer;
  logic [DATA_WIDTH-1:0]     w_mux_data;
  logic                      w_mux_last;

  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_SRC-1:0]   = src_data_valid;
    w_search                   = rr_search(w_valid_pad, 32'(r_rr_ptr), NUM_SRC);
    w_search_id                = SRC_ID_WIDTH'(w_search);
  end

  // Only the granted source, and only while locked, can drive the handshake.
  assign w_grant_valid = (r_state == ARB_LOCKED) & src_data_valid[r_grant_id];

  caxi4interconnect_Hold_Reg_Ctrl u_hold_ctrl (
    .clk                (clk),
    .rst                (rst),
    .src_data_valid     (w_grant_valid),
    .get_next_data_hold (get_next_data_hold),
    .get_next_data_src  (w_xfer),
    .hold_data_valid    (hold_data_valid)
  );

  always_comb begin
    get_next_data_src             = '0;
    get_next_data_src[r_grant_id] = w_xfer;
  end

  assign w_mux_data = src_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_mux_last = src_last[r_grant_id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|src_data_valid) begin
            r_grant_id <= w_search_id;
            r_state    <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // Grant is held through stalls; only a moved last beat releases it.
          if (w_xfer && w_mux_last) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= (r_grant_id == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : r_grant_id + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_data   <= '0;
      r_hold_last   <= 1'b0;
      r_hold_src_id <= '0;
    end else if (w_xfer) begin
      r_hold_data   <= w_mux_data;
      r_hold_last   <= w_mux_last;
      r_hold_src_id <= r_grant_id;
    end
  end

  assign hold_data   = r_hold_data;
  assign hold_last   = r_hold_last;
  assign hold_src_id = r_hold_src_id;
  assign busy        = (r_state == ARB_LOCKED);

endmodule
`default_nettype wire

// File: doc/caxi4interconnect_hold_reg_arb.md
# caxi4interconnect_hold_reg_arb

Round-robin, burst-locked arbiter that shares one output holding register between NUM_SRC source FIFOs in the AXI4 convertor datapath. Grants one source at a time, keeps the grant until that source's last beat has been moved into the holding register, then rotates priority. The output side is a single-entry holding register with a valid/get-next handshake. It presents data, last flag and source ID to the downstream channel logic.

## Interface
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_WIDTH, 64, payload width per source
- SRC_ID_WIDTH (localparam), $clog2(NUM_SRC), grant/ID width
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- src_data_valid  input  NUM_SRC  per-source data available (FIFO not empty)
- src_data  input  NUM_SRC*DATA_WIDTH  flattened payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_last  input  NUM_SRC  per-source last-beat-of-burst flag, qualified by src_data_valid
- get_next_data_src  output  NUM_SRC  one-hot (or zero) pop strobe to the granted source FIFO
- get_next_data_hold  input  1  downstream consumes holding register this cycle
- hold_data_valid  output  1  holding register contents valid
- hold_data  output  DATA_WIDTH  held payload
- hold_last  output  1  held beat is last of burst
- hold_src_id  output  SRC_ID_WIDTH  source index of held beat
- busy  output  1  burst lock active (state LOCKED)

## Operation
- pass_data = get_next_data_hold | !hold_data_valid. The holding register accepts a new beat only when pass_data is high.
- States: IDLE, LOCKED. Registers: state, grant_id, rr_ptr.
- IDLE: get_next_data_src = 0. If any src_data_valid is set, the first valid source searching upward from rr_ptr (mod NUM_SRC) is loaded into grant_id, and the next state is LOCKED. If no source is valid, stay in IDLE.
- LOCKED: get_next_data_src[grant_id] = src_data_valid[grant_id] & pass_data. All other bits are 0.
- Beat transfer occurs when get_next_data_src[grant_id] is high. At that edge the holding register loads src_data/src_last of grant_id, and hold_src_id loads grant_id.
- When the transferred beat has src_last=1: next state is IDLE and rr_ptr is set to (grant_id+1) mod NUM_SRC.
- Holding valid update: on pass_data, hold_data_valid is set to the transfer strobe (valid only if a beat actually moved). Otherwise it holds its value.
- If the granted source drops valid mid-burst, the arbiter stays LOCKED and stalls. There is no regrant and no timeout.
- Lower-priority requests are ignored while LOCKED, regardless of their valid.
- hold_data, hold_last and hold_src_id change only on a transfer. They are don't-care when hold_data_valid=0 but stable (no X after reset).
- Reset: state=IDLE, grant_id=0, rr_ptr=0, hold_data_valid=0, hold_data=0, hold_last=0, hold_src_id=0, busy=0, get_next_data_src=0.

## Timing
- Arbitration latency 1 cycle: valid seen in IDLE in cycle n, LOCKED and pop possible in cycle n+1, hold_data_valid=1 in cycle n+2.
- Throughput in LOCKED: 1 beat/cycle with downstream popping every cycle (pop and reload on the same edge).
- Burst turnaround: 1 idle cycle (IDLE) between the last beat of one burst and the first pop of the next.
- get_next_data_src is combinational from src_data_valid, get_next_data_hold, state and grant_id. There is no combinational path from src_data to outputs.
- Reset asserted mid-burst: all state clears immediately. The partially transferred burst is abandoned and must be handled upstream.

## Structure
- Shared package/include: state encoding constants (IDLE=1'b0, LOCKED=1'b1) and the round-robin search function (next valid index from pointer).
- One natural sub-module: caxi4interconnect_Hold_Reg_Ctrl for the pass_data/get-next/hold_data_valid handshake. Its src_data_valid input is driven by src_data_valid[grant_id] & (state==LOCKED).
- Data mux and holding register live in the top level.

## Test plan
- Reset mid-burst: NUM_SRC=4, src 2 locked after 2 of 4 beats, pulse rst -> all outputs 0, rr_ptr=0, busy=0. Next request from src 3 alone is granted.
- Single requester: src 1 sends a 3-beat burst, downstream always ready -> pops in cycles 1,2,3, hold_data_valid in cycles 2..4, hold_src_id=1, hold_last only on the 3rd beat.
- Contention/rotation: srcs 0,1,3 all valid, each sending 2-beat bursts -> grant order 0,1,3,0. Each burst is contiguous, with 1 IDLE cycle between bursts.
- Backpressure: get_next_data_hold=0 for 5 cycles with holding register full -> get_next_data_src=0 and hold_data stable. On release, one beat moves per cycle with no loss or duplication.
- Source stall mid-burst: granted src 0 drops valid for 3 cycles while src 2 is valid -> busy stays 1, no pop to src 2. Src 0 resumes and completes the burst.
- Single-beat bursts (src_last on first beat) from all 4 sources -> 4 grants in round-robin order, rr_ptr wraps 3->0.
